// File: rtl/aeolus_cpu_top.sv
`default_nettype none
// ============================================================================
// Module      : aeolus_cpu_top
// Description : Aeolus 8-bit accumulator CPU with program ROM (triangular
//               number root squared), 16-byte RAM and output register.
// Revision    : 1.0 - initial release
// ============================================================================
module aeolus_cpu_top (
    input  logic       boardCLK,
    input  logic       reset,
    input  logic [7:0] switches,
    output logic [7:0] cpuOut
);

    localparam logic [3:0] c_OP_NOP  = 4'h0;
    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_LDM  = 4'h2;
    localparam logic [3:0] c_OP_STM  = 4'h3;
    localparam logic [3:0] c_OP_ADD  = 4'h4;
    localparam logic [3:0] c_OP_SUB  = 4'h5;
    localparam logic [3:0] c_OP_ADDI = 4'h6;
    localparam logic [3:0] c_OP_SUBI = 4'h7;
    localparam logic [3:0] c_OP_AND  = 4'h8;
    localparam logic [3:0] c_OP_OR   = 4'h9;
    localparam logic [3:0] c_OP_IN   = 4'hA;
    localparam logic [3:0] c_OP_OUT  = 4'hB;
    localparam logic [3:0] c_OP_JMP  = 4'hC;
    localparam logic [3:0] c_OP_JZ   = 4'hD;
    localparam logic [3:0] c_OP_JC   = 4'hE;
    localparam logic [3:0] c_OP_HLT  = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] acc_q, acc_d;
    logic [7:0] out_q, out_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic [7:0] ram_q [16];

    logic [11:0] w_instr;
    logic [3:0]  w_op;
    logic [7:0]  w_k;
    logic [7:0]  w_ram_rd;
    logic [8:0]  w_sum;
    logic        w_ram_we;
    logic        w_set_z;

    assign w_op     = w_instr[11:8];
    assign w_k      = w_instr[7:0];
    assign w_ram_rd = ram_q[w_k[3:0]];
    assign cpuOut   = out_q;

    // RAM map: 0 = remaining S, 1 = n, 2 = running square, 3 = add counter
    always_comb begin
        w_instr = {c_OP_HLT, 8'h00};
        case (pc_q)
            8'd0:  w_instr = {c_OP_IN,   8'h00};
            8'd1:  w_instr = {c_OP_STM,  8'h00};
            8'd2:  w_instr = {c_OP_LDI,  8'h00};
            8'd3:  w_instr = {c_OP_STM,  8'h01};
            8'd4:  w_instr = {c_OP_LDM,  8'h01};
            8'd5:  w_instr = {c_OP_ADDI, 8'h01};
            8'd6:  w_instr = {c_OP_STM,  8'h01};
            8'd7:  w_instr = {c_OP_LDM,  8'h00};
            8'd8:  w_instr = {c_OP_SUB,  8'h01};
            8'd9:  w_instr = {c_OP_JC,   8'd28};
            8'd10: w_instr = {c_OP_STM,  8'h00};
            8'd11: w_instr = {c_OP_JZ,   8'd13};
            8'd12: w_instr = {c_OP_JMP,  8'd4};
            8'd13: w_instr = {c_OP_LDI,  8'h00};
            8'd14: w_instr = {c_OP_STM,  8'h02};
            8'd15: w_instr = {c_OP_LDM,  8'h01};
            8'd16: w_instr = {c_OP_STM,  8'h03};
            8'd17: w_instr = {c_OP_LDM,  8'h02};
            8'd18: w_instr = {c_OP_ADD,  8'h01};
            8'd19: w_instr = {c_OP_STM,  8'h02};
            8'd20: w_instr = {c_OP_LDM,  8'h03};
            8'd21: w_instr = {c_OP_SUBI, 8'h01};
            8'd22: w_instr = {c_OP_STM,  8'h03};
            8'd23: w_instr = {c_OP_JZ,   8'd25};
            8'd24: w_instr = {c_OP_JMP,  8'd17};
            8'd25: w_instr = {c_OP_LDM,  8'h02};
            8'd26: w_instr = {c_OP_OUT,  8'h00};
            8'd27: w_instr = {c_OP_HLT,  8'h00};
            8'd28: w_instr = {c_OP_LDI,  8'hFF};
            8'd29: w_instr = {c_OP_OUT,  8'h00};
            8'd30: w_instr = {c_OP_HLT,  8'h00};
            default: w_instr = {c_OP_HLT, 8'h00};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        acc_d    = acc_q;
        out_d    = out_q;
        z_d      = z_q;
        c_d      = c_q;
        w_ram_we = 1'b0;
        w_set_z  = 1'b0;
        w_sum    = 9'd0;
        if (state_q == ST_RUN) begin
            pc_d = pc_q + 8'd1;
            case (w_op)
                c_OP_NOP: ;
                c_OP_LDI: begin acc_d = w_k; w_set_z = 1'b1; end
                c_OP_LDM: begin acc_d = w_ram_rd; w_set_z = 1'b1; end
                c_OP_STM: w_ram_we = 1'b1;
                c_OP_ADD: begin
                    w_sum   = {1'b0, acc_q} + {1'b0, w_ram_rd};
                    acc_d   = w_sum[7:0];
                    c_d     = w_sum[8];
                    w_set_z = 1'b1;
                end
                c_OP_SUB: begin
                    acc_d   = acc_q - w_ram_rd;
                    c_d     = (acc_q < w_ram_rd);
                    w_set_z = 1'b1;
                end
                c_OP_ADDI: begin
                    w_sum   = {1'b0, acc_q} + {1'b0, w_k};
                    acc_d   = w_sum[7:0];
                    c_d     = w_sum[8];
                    w_set_z = 1'b1;
                end
                c_OP_SUBI: begin
                    acc_d   = acc_q - w_k;
                    c_d     = (acc_q < w_k);
                    w_set_z = 1'b1;
                end
                c_OP_AND: begin acc_d = acc_q & w_ram_rd; w_set_z = 1'b1; end
                c_OP_OR:  begin acc_d = acc_q | w_ram_rd; w_set_z = 1'b1; end
                c_OP_IN:  begin acc_d = switches; w_set_z = 1'b1; end
                c_OP_OUT: out_d = acc_q;
                c_OP_JMP: pc_d = w_k;
                c_OP_JZ:  if (z_q) pc_d = w_k;
                c_OP_JC:  if (c_q) pc_d = w_k;
                c_OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                default: ;
            endcase
            if (w_set_z) z_d = (acc_d == 8'h00);
        end
    end

    always_ff @(posedge boardCLK) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= 8'h00;
            acc_q   <= 8'h00;
            out_q   <= 8'h00;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            for (int i = 0; i < 16; i++) ram_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            z_q     <= z_d;
            c_q     <= c_d;
            if (w_ram_we) ram_q[w_k[3:0]] <= acc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aeolus_cpu_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_aeolus_cpu_top
// Description : Scoreboard bench for aeolus_cpu_top program results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aeolus_cpu_top;

    logic       boardCLK = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] switches = 8'h00;
    logic [7:0] cpuOut;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] sb_q [$];

    aeolus_cpu_top u_dut (
        .boardCLK (boardCLK),
        .reset    (reset),
        .switches (switches),
        .cpuOut   (cpuOut)
    );

    always #5 boardCLK = ~boardCLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge boardCLK);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Waits for the single OUT, compares against the scoreboard, then checks
    // that cpuOut stays put while the CPU sits halted.
    task automatic wait_result(input string tag, input int budget, input int used);
        logic [7:0] exp;
        logic [7:0] got;
        int         cyc;
        got = 8'h00;
        cyc = used;
        while (cyc < budget && cpuOut == 8'h00) begin
            tick();
            cyc++;
        end
        exp = sb_q.pop_front();
        got = (cpuOut != 8'h00) ? 8'h01 : 8'h00;
        chk({tag, "_done"}, got, 8'h01);
        chk(tag, cpuOut, exp);
        for (int i = 0; i < 30; i++) tick();
        chk({tag, "_hold"}, cpuOut, exp);
    endtask

    task automatic run_case(input string tag, input logic [7:0] sw,
                            input logic [7:0] exp, input int budget);
        switches = sw;
        do_reset();
        chk({tag, "_rst"}, cpuOut, 8'h00);
        sb_q.push_back(exp);
        wait_result(tag, budget, 0);
    endtask

    initial begin
        do_reset();
        chk("reset_state", cpuOut, 8'h00);

        run_case("t120", 8'h78, 8'hE1, 300);
        run_case("t15",  8'h0F, 8'h19, 400);

        reset = 1'b1;
        tick();
        chk("rst_after_halt", cpuOut, 8'h00);
        reset = 1'b0;

        run_case("t1",   8'h01, 8'h01, 400);
        run_case("t231", 8'hE7, 8'hB9, 400);
        run_case("s0",   8'h00, 8'hFF, 400);
        run_case("s2",   8'h02, 8'hFF, 400);

        // Mid-run reset at cycle 50, then the program must complete again.
        switches = 8'h78;
        do_reset();
        for (int i = 0; i < 50; i++) tick();
        chk("mid_pre", cpuOut, 8'h00);
        reset = 1'b1;
        tick();
        chk("mid_rst", cpuOut, 8'h00);
        reset = 1'b0;
        sb_q.push_back(8'hE1);
        wait_result("mid_rerun", 300, 0);

        switches = 8'h0F;
        for (int i = 0; i < 20; i++) tick();
        chk("halt_sw_ignored", cpuOut, 8'hE1);

        do_reset();
        sb_q.push_back(8'h19);
        wait_result("recompute", 400, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
